// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline stall sequencer.
package pipe_stall_ctrl_pkg;

  localparam int DEF_CNT_W = 6;
  localparam int STALL_W   = 6;

  // stall bit order: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb
  localparam logic [STALL_W-1:0] EX_STALL = 6'b001111;
  localparam logic [STALL_W-1:0] ID_STALL = 6'b000111;
  localparam logic [STALL_W-1:0] NONE     = 6'b000000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall request / stall vector bundle between the pipeline stages and the stall sequencer.
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               mc_start;
  logic [CNT_W-1:0]   mc_cycles;
  logic               flush;
  logic [STALL_W-1:0] stall;
  logic               mc_busy;
  logic               mc_done;
  logic [31:0]        stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, mc_start, mc_cycles, flush,
    input  stall, mc_busy, mc_done, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mc_start, mc_cycles, flush,
    output stall, mc_busy, mc_done, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl_mc_cycle_counter.sv
// Remaining-cycle down-counter for multi-cycle EX ops; never wraps below zero.
module mc_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble sequencer: merges ID/EX stall requests and times multi-cycle EX ops.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
//
// state  | meaning
// S_IDLE | no multi-cycle op; stall follows flush/mc_start/stallreq_ex/stallreq_id priority
// S_BUSY | multi-cycle op running; EX_STALL held until counter reaches zero (mc_done)
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  pipe_stall_ctrl_if.slave bus
);

  state_t             state;
  logic               mc_busy_q;
  logic [STALL_W-1:0] stall_c;
  logic               done_c;
  logic               start_ok;
  logic               do_load;
  logic               do_dec;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;

  // Reset gates the outputs so an interrupted op drops its stall in the same cycle.
  always_comb begin
    stall_c  = NONE;
    done_c   = 1'b0;
    do_load  = 1'b0;
    do_dec   = 1'b0;
    start_ok = bus.mc_start && (bus.mc_cycles != '0);
    if (!rst && !bus.flush) begin
      if (state == S_BUSY) begin
        stall_c = EX_STALL;
        done_c  = cnt_zero;
        do_dec  = !cnt_zero;
      end else if (start_ok) begin
        stall_c = EX_STALL;
        done_c  = (bus.mc_cycles == CNT_W'(1));
        do_load = (bus.mc_cycles != CNT_W'(1));
      end else if (bus.stallreq_ex) begin
        stall_c = EX_STALL;
      end else if (bus.stallreq_id) begin
        stall_c = ID_STALL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mc_busy_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (do_load) begin
            state     <= S_BUSY;
            mc_busy_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (bus.flush || cnt_zero) begin
            state     <= S_IDLE;
            mc_busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          mc_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Counter holds N-2: the start cycle and the final (done) cycle are not counted down.
  mc_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_mc_cycle_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .load     (do_load),
    .load_val (bus.mc_cycles - CNT_W'(2)),
    .dec      (do_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign bus.stall   = stall_c;
  assign bus.mc_done = done_c;
  assign bus.mc_busy = mc_busy_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall_c[0] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.stall_cycles = perf_q;
`else
  assign bus.stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if #(.CNT_W(6)) bus ();

  pipe_stall_ctrl #(.CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then settle to the falling edge.
  task automatic drive(input logic id, input logic ex, input logic st,
                       input logic [5:0] n, input logic fl);
    @(posedge clk);
    #1;
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.mc_start    = st;
    bus.mc_cycles   = n;
    bus.flush       = fl;
    #4;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] s,
                         input logic busy, input logic done);
    chk({tag, ".stall"}, {26'd0, bus.stall}, {26'd0, s});
    chk({tag, ".busy"},  {31'd0, bus.mc_busy}, {31'd0, busy});
    chk({tag, ".done"},  {31'd0, bus.mc_done}, {31'd0, done});
  endtask

  initial begin
    logic [31:0] perf_exp;
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.mc_start    = 1'b0;
    bus.mc_cycles   = 6'd0;
    bus.flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 6'b000000, 1'b0, 1'b0);
    chk("reset.perf", bus.stall_cycles, 32'd0);
    rst = 1'b0;

    // priority between single-cycle requests
    drive(1, 0, 0, 0, 0); chk_out("prio.id",   6'b000111, 0, 0);
    drive(1, 1, 0, 0, 0); chk_out("prio.both", 6'b001111, 0, 0);
    drive(0, 1, 0, 0, 0); chk_out("prio.ex",   6'b001111, 0, 0);
    drive(0, 0, 0, 0, 0); chk_out("prio.none", 6'b000000, 0, 0);

    // N=5 op: five stalled cycles, done in the last one
    drive(0, 0, 1, 6'd5, 0); chk_out("n5.t0", 6'b001111, 0, 0);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 0); chk_out("n5.mid", 6'b001111, 1, 0);
    end
    drive(0, 0, 0, 0, 0); chk_out("n5.t4", 6'b001111, 1, 1);
    drive(0, 0, 0, 0, 0); chk_out("n5.t5", 6'b000000, 0, 0);

    // edge lengths
    drive(0, 0, 1, 6'd0, 0); chk_out("n0", 6'b000000, 0, 0);
    drive(1, 0, 1, 6'd0, 0); chk_out("n0.id", 6'b000111, 0, 0);
    drive(0, 0, 1, 6'd1, 0); chk_out("n1", 6'b001111, 0, 1);
    drive(0, 0, 0, 0, 0);    chk_out("n1.after", 6'b000000, 0, 0);
    drive(1, 1, 1, 6'd1, 1); chk_out("flush.idle", 6'b000000, 0, 0);

    // flush in cycle 2 of an N=8 op
    drive(0, 0, 1, 6'd8, 0); chk_out("fl.t0", 6'b001111, 0, 0);
    drive(0, 0, 0, 0, 1);    chk_out("fl.t1", 6'b000000, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0); chk_out("fl.after", 6'b000000, 0, 0);
    end

    // N=8 op with an ignored N=3 restart and absorbed requests
    drive(0, 0, 1, 6'd8, 0); chk_out("n8.t0", 6'b001111, 0, 0);
    drive(1, 1, 1, 6'd3, 0); chk_out("n8.t1", 6'b001111, 1, 0);
    for (int i = 2; i < 7; i++) begin
      drive(0, 0, 0, 0, 0); chk_out("n8.mid", 6'b001111, 1, 0);
    end
    drive(0, 0, 0, 0, 0); chk_out("n8.t7", 6'b001111, 1, 1);
    drive(0, 0, 0, 0, 0); chk_out("n8.t8", 6'b000000, 0, 0);

    // reset three cycles into an N=10 op
    drive(0, 0, 1, 6'd10, 0); chk_out("rst.t0", 6'b001111, 0, 0);
    drive(0, 0, 0, 0, 0);     chk_out("rst.t1", 6'b001111, 1, 0);
    drive(0, 0, 0, 0, 0);     chk_out("rst.t2", 6'b001111, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_out("rst.now", 6'b000000, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0); chk_out("rst.after", 6'b000000, 0, 0);
    end

    // performance counter: 4 ID stalls + N=5 op = 9 stalled cycles
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("perf.clr", bus.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 6'd5, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    perf_exp = 32'd9;
`else
    perf_exp = 32'd0;
`endif
    chk("perf.count", bus.stall_cycles, perf_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
